// File: rtl/pc_gen.sv
// pc_gen: program counter ahead of a registered fetch; handles stall replay, redirects, traps, halt and range faults.
module pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
  parameter int          IMEM_BYTES  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        trap,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        misaligned,
  output logic [31:0] bad_addr,
  output logic        fault,
  output logic        halted
);
  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);
  typedef enum logic {RUN, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] npc_q, npc_d, ipc_q, ipc_d, bad_q, bad_d;
  logic        valid_q, valid_d, mis_q, mis_d, fault_q, fault_d;
  always_comb begin
    state_d = state_q;
    npc_d   = npc_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    mis_d   = 1'b0;
    bad_d   = bad_q;
    fault_d = fault_q;
    if (state_q == HALT) begin
      valid_d = 1'b0;
    end else if (halt) begin
      state_d = HALT;
      valid_d = 1'b0;
    end else if (!stall && !trap && !redirect && npc_q > LAST_PC) begin
      fault_d = 1'b1;
      state_d = HALT;
      valid_d = 1'b0;
    end else if (trap || redirect) begin
      // a misaligned redirect is turned into a trap and reported
      mis_d   = !trap && (redirect_target[1:0] != 2'b00);
      npc_d   = (trap || mis_d) ? TRAP_VECTOR : redirect_target;
      bad_d   = mis_d ? redirect_target : bad_q;
      valid_d = 1'b0;
    end else if (!stall) begin
      ipc_d   = npc_q;
      valid_d = 1'b1;
      npc_d   = npc_q + 32'd4;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      npc_q   <= RESET_PC;
      ipc_q   <= RESET_PC;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      bad_q   <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      npc_q   <= npc_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      bad_q   <= bad_d;
      fault_q <= fault_d;
    end
  end
  // replaying the held address keeps the registered fetch output stable
  assign pc          = stall ? ipc_q : npc_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign misaligned  = mis_q;
  assign bad_addr    = bad_q;
  assign fault       = fault_q;
  assign halted      = (state_q == HALT);
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed table, randomized model comparison and end-of-memory fault run for pc_gen.
module tb_pc_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, stall_a, redirect_a, trap_a, halt_a;
  logic [31:0] target_a, pc_a, ipc_a, bad_a, instr_a;
  logic        valid_a, mis_a, fault_a, halted_a;
  logic        rst_b, stall_b, redirect_b, trap_b, halt_b;
  logic [31:0] target_b, pc_b, ipc_b, bad_b, instr_b;
  logic        valid_b, mis_b, fault_b, halted_b;
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [4];
  int n_cmp = 0, n_err = 0;

  pc_gen dut_a (.clk(clk), .rst(rst_a), .stall(stall_a), .redirect(redirect_a),
    .redirect_target(target_a), .trap(trap_a), .halt(halt_a), .pc(pc_a), .instr_pc(ipc_a),
    .instr_valid(valid_a), .misaligned(mis_a), .bad_addr(bad_a), .fault(fault_a), .halted(halted_a));
  pc_gen #(.IMEM_BYTES(16)) dut_b (.clk(clk), .rst(rst_b), .stall(stall_b), .redirect(redirect_b),
    .redirect_target(target_b), .trap(trap_b), .halt(halt_b), .pc(pc_b), .instr_pc(ipc_b),
    .instr_valid(valid_b), .misaligned(mis_b), .bad_addr(bad_b), .fault(fault_b), .halted(halted_b));

  // stand-in for the fetch stage: one-cycle registered read
  always @(posedge clk) begin
    instr_a <= mem_a[pc_a[9:2]];
    instr_b <= mem_b[pc_b[3:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic st, rd; logic [31:0] tgt; logic tr, ht;
    logic [31:0] pc, ipc; logic v, mis; logic [31:0] bad; logic hlt;
  } vec_t;
  vec_t tbl [18];

  // reference model: what the fetch pipeline should look like after each edge
  logic [31:0] m_npc, m_ipc, m_bad;
  logic        m_v, m_mis, m_fault, m_halted;

  task automatic model_reset();
    m_npc = 0; m_ipc = 0; m_bad = 0;
    m_v = 0; m_mis = 0; m_fault = 0; m_halted = 0;
  endtask

  task automatic model_step(input logic st, rd, input logic [31:0] tgt, input logic tr, ht);
    logic was_mis;
    was_mis = 0;
    if (m_halted) begin
      m_v = 0;
    end else if (ht) begin
      m_halted = 1; m_v = 0;
    end else if (tr) begin
      m_npc = 32'h100; m_v = 0;
    end else if (rd) begin
      m_v = 0;
      if (tgt % 4 != 0) begin
        m_npc = 32'h100; m_bad = tgt; was_mis = 1;
      end else m_npc = tgt;
    end else if (!st) begin
      if (m_npc > 1020) begin
        m_fault = 1; m_halted = 1; m_v = 0;
      end else begin
        m_ipc = m_npc; m_v = 1; m_npc = m_npc + 4;
      end
    end
    m_mis = was_mis;
  endtask

  task automatic cmp_a(input string tag);
    chk({tag, " pc"}, pc_a, stall_a ? m_ipc : m_npc);
    chk({tag, " instr_pc"}, ipc_a, m_ipc);
    chk({tag, " instr_valid"}, 32'(valid_a), 32'(m_v));
    chk({tag, " misaligned"}, 32'(mis_a), 32'(m_mis));
    chk({tag, " bad_addr"}, bad_a, m_bad);
    chk({tag, " fault"}, 32'(fault_a), 32'(m_fault));
    chk({tag, " halted"}, 32'(halted_a), 32'(m_halted));
    if (m_v && !rst_a) chk({tag, " instr"}, instr_a, mem_a[m_ipc[9:2]]);
  endtask

  initial begin
    logic [31:0] last_ipc;
    int nvalid;
    bit seen;
    for (int i = 0; i < 256; i++) mem_a[i] = $urandom;
    for (int i = 0; i < 4; i++) mem_b[i] = $urandom;
    {stall_a, redirect_a, trap_a, halt_a, target_a} = '0;
    {stall_b, redirect_b, trap_b, halt_b, target_b} = '0;
    rst_a = 1; rst_b = 1;
    tbl[0]  = '{0,0,32'h0, 0,0, 32'h0,   32'h0,   0,0,32'h0, 0};
    tbl[1]  = '{0,0,32'h0, 0,0, 32'h4,   32'h0,   1,0,32'h0, 0};
    tbl[2]  = '{1,0,32'h0, 0,0, 32'h4,   32'h4,   1,0,32'h0, 0};
    tbl[3]  = '{1,0,32'h0, 0,0, 32'h4,   32'h4,   1,0,32'h0, 0};
    tbl[4]  = '{1,0,32'h0, 0,0, 32'h4,   32'h4,   1,0,32'h0, 0};
    tbl[5]  = '{0,0,32'h0, 0,0, 32'h8,   32'h4,   1,0,32'h0, 0};
    tbl[6]  = '{0,0,32'h0, 0,0, 32'hC,   32'h8,   1,0,32'h0, 0};
    tbl[7]  = '{1,1,32'h40,0,0, 32'hC,   32'hC,   1,0,32'h0, 0};
    tbl[8]  = '{0,0,32'h0, 0,0, 32'h40,  32'hC,   0,0,32'h0, 0};
    tbl[9]  = '{0,1,32'h42,0,0, 32'h44,  32'h40,  1,0,32'h0, 0};
    tbl[10] = '{0,0,32'h0, 0,0, 32'h100, 32'h40,  0,1,32'h42,0};
    tbl[11] = '{0,1,32'h40,1,0, 32'h104, 32'h100, 1,0,32'h42,0};
    tbl[12] = '{1,0,32'h0, 0,0, 32'h100, 32'h100, 0,0,32'h42,0};
    tbl[13] = '{0,0,32'h0, 0,0, 32'h100, 32'h100, 0,0,32'h42,0};
    tbl[14] = '{0,0,32'h0, 0,0, 32'h104, 32'h100, 1,0,32'h42,0};
    tbl[15] = '{0,0,32'h0, 0,1, 32'h108, 32'h104, 1,0,32'h42,0};
    tbl[16] = '{0,1,32'h40,0,0, 32'h108, 32'h104, 0,0,32'h42,1};
    tbl[17] = '{1,0,32'h0, 0,0, 32'h104, 32'h104, 0,0,32'h42,1};

    @(negedge clk); #1;
    chk("rst pc", pc_a, 32'h0);
    chk("rst instr_pc", ipc_a, 32'h0);
    chk("rst valid/mis/fault/halted", {28'd0, valid_a, mis_a, fault_a, halted_a}, 32'h0);
    chk("rst bad_addr", bad_a, 32'h0);
    @(posedge clk); #1 rst_a = 0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      stall_a = tbl[i].st; redirect_a = tbl[i].rd; target_a = tbl[i].tgt;
      trap_a = tbl[i].tr; halt_a = tbl[i].ht;
      #1;
      chk($sformatf("vec%0d pc", i), pc_a, tbl[i].pc);
      chk($sformatf("vec%0d instr_pc", i), ipc_a, tbl[i].ipc);
      chk($sformatf("vec%0d instr_valid", i), 32'(valid_a), 32'(tbl[i].v));
      chk($sformatf("vec%0d misaligned", i), 32'(mis_a), 32'(tbl[i].mis));
      chk($sformatf("vec%0d bad_addr", i), bad_a, tbl[i].bad);
      chk($sformatf("vec%0d halted", i), 32'(halted_a), 32'(tbl[i].hlt));
      chk($sformatf("vec%0d fault", i), 32'(fault_a), 32'h0);
      if (tbl[i].v) chk($sformatf("vec%0d instr", i), instr_a, mem_a[tbl[i].ipc[9:2]]);
    end

    @(negedge clk);
    {stall_a, redirect_a, trap_a, halt_a, target_a} = '0;
    rst_a = 1; model_reset();
    @(posedge clk); #1 rst_a = 0;
    for (int k = 0; k < 3000; k++) begin
      int r, t;
      @(negedge clk);
      r = $urandom_range(0, 399);
      rst_a = (r == 0);
      halt_a = (r == 1);
      stall_a = ($urandom_range(0, 3) == 0);
      redirect_a = ($urandom_range(0, 9) == 0);
      trap_a = ($urandom_range(0, 24) == 0);
      t = $urandom_range(0, 9);
      target_a = (t < 7) ? {22'd0, 8'($urandom_range(0, 255)), 2'b00} :
                 (t < 9) ? {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))} :
                           32'h400 + {$urandom_range(0, 1023), 2'b00};
      if (rst_a) model_reset();
      #1 cmp_a("rand");
      @(posedge clk);
      if (!rst_a) model_step(stall_a, redirect_a, target_a, trap_a, halt_a);
    end
    @(negedge clk);
    {stall_a, redirect_a, trap_a, halt_a, rst_a} = '0;

    @(posedge clk); #1 rst_b = 0;
    nvalid = 0; last_ipc = 32'hFFFF_FFFF; seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk); #1;
      if (fault_b) seen = 1;
      else if (valid_b) begin
        chk("end instr_pc step", ipc_b, 32'(nvalid * 4));
        chk("end instr", instr_b, mem_b[nvalid]);
        last_ipc = ipc_b;
        nvalid++;
      end
    end
    chk("end fault reached", 32'(seen), 32'h1);
    chk("end last valid instr_pc", last_ipc, 32'hC);
    chk("end valid count", 32'(nvalid), 32'd4);
    chk("end halted", 32'(halted_b), 32'h1);
    chk("end valid after fault", 32'(valid_b), 32'h0);
    chk("end pc after fault", pc_b, 32'h10);
    halt_b = 1; redirect_b = 1; target_b = 32'h4;
    repeat (3) @(negedge clk);
    #1;
    chk("halt ignores pc", pc_b, 32'h10);
    chk("halt ignores instr_pc", ipc_b, 32'hC);
    chk("halt ignores valid", 32'(valid_b), 32'h0);
    chk("halt keeps fault", 32'(fault_b), 32'h1);
    chk("halt keeps halted", 32'(halted_b), 32'h1);
    #1 rst_b = 1;
    #1;
    chk("async rst instr_pc", ipc_b, 32'h0);
    chk("async rst pc", pc_b, 32'h0);
    chk("async rst fault", 32'(fault_b), 32'h0);
    chk("async rst halted", 32'(halted_b), 32'h0);
    @(negedge clk);
    {halt_b, redirect_b, rst_b} = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
